// File: rtl/mux32_32x1_reg_pkg.sv
// Shared constants and the default word type for the 32:1 registered word multiplexer.
package mux32_pkg;

  localparam int NUM_IN    = 32;
  localparam int SEL_W     = 5;
  localparam int DEF_WIDTH = 32;

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/mux32_32x1_reg_if.sv
// Bus bundle for mux32_32x1_reg: 32 data words, select, registered and optional comb outputs.
// out_comb exists only when MUX32_COMB_OUT_EN is defined.
interface mux32_32x1_reg_if
  import mux32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] in_data [NUM_IN];
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] out;
`ifdef MUX32_COMB_OUT_EN
  logic [WIDTH-1:0] out_comb;
`endif

  modport master (
    output in_data,
    output sel,
`ifdef MUX32_COMB_OUT_EN
    input  out_comb,
`endif
    input  out
  );

  modport slave (
    input  in_data,
    input  sel,
`ifdef MUX32_COMB_OUT_EN
    output out_comb,
`endif
    output out
  );

endinterface

// File: rtl/mux32_32x1_reg_mux8.sv
// mux_8x1_w: combinational 8:1 word multiplexer, one leaf of the 32:1 select tree.
module mux_8x1_w #(
  parameter int WIDTH = 32
) (
  input  logic [7:0][WIDTH-1:0] d,
  input  logic [2:0]            sel,
  output logic [WIDTH-1:0]      y
);

  assign y = d[sel];

endmodule

// File: rtl/mux32_32x1_reg.sv
// mux32_32x1_reg: 32:1 word mux (four 8:1 leaves plus a 4:1 root) with a registered output.
// Defining MUX32_COMB_OUT_EN adds out_comb, the unregistered tree output.
module mux32_32x1_reg
  import mux32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux32_32x1_reg_if.slave        bus
);

  localparam int LEAF_N  = 8;
  localparam int NUM_GRP = NUM_IN / LEAF_N;

  logic [LEAF_N-1:0][WIDTH-1:0] grp_in  [NUM_GRP];
  logic [WIDTH-1:0]             grp_out [NUM_GRP];
  logic [WIDTH-1:0]             tree_out;

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_leaf
    for (genvar k = 0; k < LEAF_N; k++) begin : g_word
      assign grp_in[g][k] = bus.in_data[g*LEAF_N + k];
    end

    mux_8x1_w #(
      .WIDTH (WIDTH)
    ) u_mux8 (
      .d   (grp_in[g]),
      .sel (bus.sel[2:0]),
      .y   (grp_out[g])
    );
  end

  // NOTE: assign a default before the case so every path drives tree_out and no latch is inferred.
  always_comb begin
    tree_out = grp_out[0];
    case (bus.sel[4:3])
      2'd1:    tree_out = grp_out[1];
      2'd2:    tree_out = grp_out[2];
      2'd3:    tree_out = grp_out[3];
      default: tree_out = grp_out[0];
    endcase
  end

  // NOTE: state uses non-blocking assignments; the clear is in the sensitivity list so it acts without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out <= '0;
    end else begin
      bus.out <= tree_out;
    end
  end

`ifdef MUX32_COMB_OUT_EN
  assign bus.out_comb = tree_out;
`endif

endmodule

// File: tb/tb_mux32_32x1_reg.sv
// Self-checking bench for mux32_32x1_reg: table sweep/wrap, reset, tracking, optional comb tap, random run.
module tb_mux32_32x1_reg;
  import mux32_pkg::*;

  logic clk;
  logic rst_n;

  mux32_32x1_reg_if #(.WIDTH(DEF_WIDTH)) bus ();

  mux32_32x1_reg #(
    .WIDTH (DEF_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] sel;
    word_t            exp;
  } vec_t;

  int    checks;
  int    errors;
  word_t model_in [NUM_IN];
  vec_t  vecs [34];

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_inputs();
    for (int k = 0; k < NUM_IN; k++) bus.in_data[k] = model_in[k];
  endtask

  // Apply a select at the falling edge, then let the next rising edge capture it.
  task automatic step(input logic [SEL_W-1:0] s);
    @(negedge clk);
    bus.sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t exp_w;
    logic [SEL_W-1:0] rs;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.sel = '0;
    for (int k = 0; k < NUM_IN; k++) model_in[k] = word_t'(1) << k;
    load_inputs();

    #3;
    check("reset_async_initial", bus.out, '0);
    @(posedge clk); #1;
    check("reset_held_over_edge", bus.out, '0);

    // T1 sweep and T2 wrap, table-driven.
    for (int k = 0; k < NUM_IN; k++) begin
      vecs[k].sel = k[SEL_W-1:0];
      vecs[k].exp = word_t'(1) << k;
    end
    vecs[32].sel = 5'd31; vecs[32].exp = 32'h8000_0000;
    vecs[33].sel = 5'd0;  vecs[33].exp = 32'h0000_0001;

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      step(vecs[i].sel);
      check($sformatf("table_sel%0d_i%0d", vecs[i].sel, i), bus.out, vecs[i].exp);
    end

    // T3 async reset between edges, then release with sel = 9.
    step(5'd5);
    check("pre_reset_sel5", bus.out, 32'h0000_0020);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_cycle", bus.out, '0);
    @(posedge clk); #1;
    check("reset_mid_held", bus.out, '0);
    @(negedge clk);
    bus.sel = 5'd9;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    check("release_sel9", bus.out, 32'h0000_0200);

    // T4 data tracking on a held select.
    model_in[17] = 32'hDEAD_BEEF;
    @(negedge clk); load_inputs();
    step(5'd17);
    check("track_deadbeef", bus.out, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int k = 0; k < NUM_IN; k++) if (k != 17) bus.in_data[k] = $urandom;
    @(posedge clk); #1;
    check("unselected_change", bus.out, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.in_data[17] = 32'h1234_5678;
    #1 check("track_not_yet", bus.out, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("track_new_value", bus.out, 32'h1234_5678);

`ifdef MUX32_COMB_OUT_EN
    // T5 combinational tap.
    for (int k = 0; k < NUM_IN; k++) model_in[k] = word_t'(1) << k;
    @(negedge clk);
    load_inputs();
    bus.sel = 5'd30;
    #1 check("comb_same_cycle", bus.out_comb, 32'h4000_0000);
    @(posedge clk); #1;
    check("comb_reg_follow", bus.out, 32'h4000_0000);
    rst_n = 1'b0;
    #1 check("comb_in_reset", bus.out_comb, 32'h4000_0000);
    check("reg_in_reset", bus.out, '0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // T6 random inputs and select against an array model.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_IN; k++) model_in[k] = $urandom;
      rs = SEL_W'($urandom_range(NUM_IN - 1, 0));
      load_inputs();
      bus.sel = rs;
      exp_w = model_in[rs];
      @(posedge clk); #1;
      check($sformatf("random_%0d_sel%0d", n, rs), bus.out, exp_w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
